// File: rtl/execute_bru_pkg.sv
// Shared widths and field offsets for the BRU issue FIFO.
// The packed uop and branch-prediction bundles are described here.
package execute_bru_pkg;

  localparam int PC_W       = 32;
  localparam int SRC_W      = 32;
  localparam int IMM_W      = 26;
  localparam int BRU_CMD_W  = 7;
  localparam int BAGU_CMD_W = 2;
  localparam int ROB_W      = 4;
  localparam int FID_W      = 8;

  localparam int UOP_FIX_W  = PC_W + 2 * SRC_W + IMM_W
                            + BRU_CMD_W + BAGU_CMD_W;
  localparam int UOP_W      = UOP_FIX_W + ROB_W + FID_W;

  localparam int BAGU_LSB   = 0;
  localparam int BRU_LSB    = BAGU_LSB + BAGU_CMD_W;
  localparam int FID_LSB    = BRU_LSB + BRU_CMD_W;
  localparam int IMM_LSB    = FID_LSB + FID_W;
  localparam int ROB_LSB    = IMM_LSB + IMM_W;
  localparam int SRC1_LSB   = ROB_LSB + ROB_W;
  localparam int SRC0_LSB   = SRC1_LSB + SRC_W;
  localparam int PC_LSB     = SRC0_LSB + SRC_W;

  localparam int BP_TGT_W   = 32;
  localparam int BP_PAT_W   = 2;
  localparam int BP_W       = BP_TGT_W + 2 + BP_PAT_W;
  localparam int BP_TGT_LSB = 0;
  localparam int BP_HIT_BIT = BP_TGT_LSB + BP_TGT_W;
  localparam int BP_TKN_BIT = BP_HIT_BIT + 1;
  localparam int BP_PAT_LSB = BP_TKN_BIT + 1;

  function automatic int uop_w(input int rob_w, input int fid_w);
    return UOP_FIX_W + rob_w + fid_w;
  endfunction

endpackage

// File: rtl/execute_bru_pipe_ram.sv
// Entry storage: one write port, one asynchronous read port.
// Contents are deliberately not reset.
module execute_bru_pipe_ram #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/execute_bru_pipe.sv
// In-order BRU issue FIFO of DEPTH entries.
// Define EXECUTE_BRU_PIPE_BP_EN to carry i_bp alongside each uop.
module execute_bru_pipe
  import execute_bru_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int ROB_W = 4,
  parameter int FID_W = 8,
  localparam int UW   = uop_w(ROB_W, FID_W),
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          i_flush,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [UW-1:0] i_uop,
  input  logic [BP_W-1:0] i_bp,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [UW-1:0] o_uop,
  output logic [BP_W-1:0] o_bp,
  output logic [CW-1:0] o_count
);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  assign o_ready = count < CW'(DEPTH);
  assign o_valid = count != '0;
  assign o_count = count;
  assign push    = i_valid && o_ready && !i_flush;
  assign pop     = o_valid && i_ready && !i_flush;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef EXECUTE_BRU_PIPE_BP_EN
  logic [UW+BP_W-1:0] rd_ent;

  execute_bru_pipe_ram #(
    .DEPTH (DEPTH),
    .WIDTH (UW + BP_W)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata ({i_bp, i_uop}),
    .raddr (rd_ptr),
    .rdata (rd_ent)
  );

  assign o_uop = rd_ent[UW-1:0];
  assign o_bp  = rd_ent[UW+BP_W-1:UW];
`else
  logic unused_bp;

  execute_bru_pipe_ram #(
    .DEPTH (DEPTH),
    .WIDTH (UW)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (i_uop),
    .raddr (rd_ptr),
    .rdata (o_uop)
  );

  assign unused_bp = ^i_bp;
  assign o_bp      = '0;
`endif

endmodule

// File: tb/tb_execute_bru_pipe.sv
// Bench: DEPTH=2 and DEPTH=4 instances share stimulus;
// each is compared against its own queue model.
module tb_execute_bru_pipe;
  import execute_bru_pkg::*;

`ifdef EXECUTE_BRU_PIPE_BP_EN
  localparam bit BP_EN = 1'b1;
`else
  localparam bit BP_EN = 1'b0;
`endif

  typedef logic [UOP_W+BP_W-1:0] ent_t;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            i_flush = 1'b0;
  logic            i_valid = 1'b0;
  logic            i_ready = 1'b0;
  logic [UOP_W-1:0] i_uop = '0;
  logic [BP_W-1:0]  i_bp = '0;

  logic            r2, v2, r4, v4;
  logic [UOP_W-1:0] u2, u4;
  logic [BP_W-1:0]  b2, b4;
  logic [1:0]      c2;
  logic [2:0]      c4;

  ent_t q2[$];
  ent_t q4[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  execute_bru_pipe #(.DEPTH(2)) d2 (
    .clk(clk), .resetn(resetn), .i_flush(i_flush),
    .i_valid(i_valid), .o_ready(r2), .i_uop(i_uop),
    .i_bp(i_bp), .o_valid(v2), .i_ready(i_ready),
    .o_uop(u2), .o_bp(b2), .o_count(c2)
  );

  execute_bru_pipe #(.DEPTH(4)) d4 (
    .clk(clk), .resetn(resetn), .i_flush(i_flush),
    .i_valid(i_valid), .o_ready(r4), .i_uop(i_uop),
    .i_bp(i_bp), .o_valid(v4), .i_ready(i_ready),
    .o_uop(u4), .o_bp(b4), .o_count(c4)
  );

  task automatic check(input string tag,
                       input logic [255:0] obs,
                       input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [UOP_W-1:0] rand_uop();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[UOP_W-1:0];
  endfunction

  function automatic logic [BP_W-1:0] rand_bp();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[BP_W-1:0];
  endfunction

  task automatic check_all();
    ent_t e;
    check("cnt2", c2, q2.size());
    check("vld2", v2, q2.size() != 0);
    check("rdy2", r2, q2.size() < 2);
    if (q2.size() != 0) begin
      e = q2[0];
      check("uop2", u2, e[UOP_W-1:0]);
      check("bp2", b2, e[UOP_W+BP_W-1:UOP_W]);
    end
    check("cnt4", c4, q4.size());
    check("vld4", v4, q4.size() != 0);
    check("rdy4", r4, q4.size() < 4);
    if (q4.size() != 0) begin
      e = q4[0];
      check("uop4", u4, e[UOP_W-1:0]);
      check("bp4", b4, e[UOP_W+BP_W-1:UOP_W]);
    end
  endtask

  // One clock: drive at negedge, update model at posedge, check after.
  task automatic step(input logic rn, input logic fl,
                      input logic v, input logic r,
                      input logic [UOP_W-1:0] u,
                      input logic [BP_W-1:0] b,
                      output logic acc4);
    bit   push2, pop2, push4, pop4;
    ent_t e;
    @(negedge clk);
    resetn  = rn;
    i_flush = fl;
    i_valid = v;
    i_ready = r;
    i_uop   = u;
    i_bp    = b;
    e = {(BP_EN ? b : {BP_W{1'b0}}), u};
    push2 = v && q2.size() < 2 && !fl;
    pop2  = r && q2.size() != 0 && !fl;
    push4 = v && q4.size() < 4 && !fl;
    pop4  = r && q4.size() != 0 && !fl;
    acc4  = rn && push4;
    @(posedge clk);
    if (!rn || fl) begin
      q2.delete();
      q4.delete();
    end else begin
      if (pop2) void'(q2.pop_front());
      if (push2) q2.push_back(e);
      if (pop4) void'(q4.pop_front());
      if (push4) q4.push_back(e);
    end
    #1;
    check_all();
  endtask

  logic             acc;
  logic [UOP_W-1:0] u;
  logic [BP_W-1:0]  bp;
  int               idx;
  int               budget;

  initial begin
    step(0, 0, 0, 0, '0, '0, acc);
    step(0, 1, 1, 1, rand_uop(), rand_bp(), acc);

    u = rand_uop();
    u[PC_LSB +: PC_W] = 32'h1000;
    step(1, 0, 1, 0, u, rand_bp(), acc);
    check("pc2", u2[PC_LSB +: PC_W], 32'h1000);
    check("v2_first", v2, 1'b1);

    step(1, 0, 1, 0, rand_uop(), rand_bp(), acc);
    step(1, 0, 1, 0, rand_uop(), rand_bp(), acc);
    check("full_cnt2", c2, 2'd2);
    check("full_rdy2", r2, 1'b0);
    check("cnt4_3", c4, 3'd3);

    step(1, 0, 1, 1, rand_uop(), rand_bp(), acc);
    check("popfull_cnt2", c2, 2'd1);
    step(1, 0, 1, 0, rand_uop(), rand_bp(), acc);
    check("refill_cnt2", c2, 2'd2);

    step(1, 1, 1, 0, rand_uop(), rand_bp(), acc);
    check("flush_cnt2", c2, 2'd0);
    check("flush_v4", v4, 1'b0);

    bp = '0;
    bp[BP_TGT_LSB +: BP_TGT_W] = 32'hDEAD0000;
    step(1, 0, 1, 0, rand_uop(), bp, acc);
    check("bptgt", b2[BP_TGT_LSB +: BP_TGT_W],
          BP_EN ? 32'hDEAD0000 : 32'h0);
    step(1, 1, 0, 0, '0, '0, acc);

    // Upstream retries each entry until the DEPTH=4 copy takes it.
    idx = 0;
    budget = 0;
    u = rand_uop();
    bp = rand_bp();
    while (idx < 10 && budget < 100) begin
      step(1, 0, 1, (budget % 2) == 0, u, bp, acc);
      if (acc) begin
        idx++;
        u = rand_uop();
        bp = rand_bp();
      end
      budget++;
    end
    check("stream_done", idx, 10);
    budget = 0;
    while (q4.size() != 0 && budget < 20) begin
      step(1, 0, 0, 1, '0, '0, acc);
      budget++;
    end
    check("drain4", c4, 3'd0);

    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(63) != 0),
           ($urandom_range(15) == 0),
           $urandom_range(1), $urandom_range(1),
           rand_uop(), rand_bp(), acc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
